// File: rtl/water_inlet_arbiter.sv
// -----------------------------------------------------------------------------
// water_inlet_arbiter
//   Shares one mains water inlet valve among NUM_MACHINES washing machine
//   controllers. Requests are served one at a time in round-robin order. Each
//   grant lasts at most FILL_TICKS cycles, and a GAP_TICKS settle gap follows
//   every grant so the valve is closed before the next arbitration.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   synchronous active-low reset
//   req        in   [NUM_MACHINES] per-machine fill request (level)
//   pause      in   global pause; freezes the phase counter
//   prio_req   in   [NUM_MACHINES] priority class (only with WATER_ARB_PRIO_EN)
//   grant      out  [NUM_MACHINES] one-hot or zero grant, registered
//   valve_open out  inlet valve drive, (state==GRANT) & ~pause
//   busy       out  high whenever state != IDLE, registered
//   fill_cnt   out  [CNT_W] current phase counter, registered
//
// Build option:
//   WATER_ARB_PRIO_EN - adds prio_req; requests that also assert prio_req win
//                       arbitration over plain requests (shared rr pointer).
// -----------------------------------------------------------------------------
module water_inlet_arbiter #(
    parameter int NUM_MACHINES = 4,
    parameter int FILL_TICKS   = 10,
    parameter int GAP_TICKS    = 2,
    parameter int CNT_W        = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_MACHINES-1:0] req,
    input  logic                    pause,
`ifdef WATER_ARB_PRIO_EN
    input  logic [NUM_MACHINES-1:0] prio_req,
`endif
    output logic [NUM_MACHINES-1:0] grant,
    output logic                    valve_open,
    output logic                    busy,
    output logic [CNT_W-1:0]        fill_cnt
);

    localparam int PTR_W = (NUM_MACHINES > 1) ? $clog2(NUM_MACHINES) : 1;

    typedef enum logic [1:0] {IDLE, GRANT, SETTLE} state_t;

    state_t                  state_q, state_d;
    logic [NUM_MACHINES-1:0] grant_q, grant_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [PTR_W-1:0]        rr_q, rr_d;
    logic [PTR_W-1:0]        gidx_q, gidx_d;  // index of current grantee
    logic                    busy_q, busy_d;

    // ---------------- arbitration ----------------
    logic [NUM_MACHINES-1:0] cand;
    logic                    win_vld;
    logic [PTR_W-1:0]        win_idx;
    logic [NUM_MACHINES-1:0] win_oh;
    logic [PTR_W-1:0]        win_next;

    always_comb begin
`ifdef WATER_ARB_PRIO_EN
        // Priority requests, when any are present, hide all plain requests.
        cand = (|(req & prio_req)) ? (req & prio_req) : req;
`else
        cand = req;
`endif
        win_vld = 1'b0;
        win_idx = '0;
        win_oh  = '0;
        // Rotating scan starting at rr_q; first set bit wins.
        for (int i = 0; i < NUM_MACHINES; i++) begin
            int idx;
            idx = int'(rr_q) + i;
            if (idx >= NUM_MACHINES) idx = idx - NUM_MACHINES;
            if (!win_vld && cand[idx]) begin
                win_vld     = 1'b1;
                win_idx     = PTR_W'(idx);
                win_oh[idx] = 1'b1;
            end
        end
        win_next = (int'(win_idx) == NUM_MACHINES - 1) ? '0 : win_idx + 1'b1;
    end

    // ---------------- next state ----------------
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        rr_d    = rr_q;
        gidx_d  = gidx_q;

        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    state_d = GRANT;
                    grant_d = win_oh;
                    cnt_d   = '0;
                    gidx_d  = win_idx;
                    rr_d    = win_next;
                end
            end
            GRANT: begin
                // Early release beats both pause and timeout.
                if (!req[gidx_q]) begin
                    state_d = SETTLE;
                    grant_d = '0;
                    cnt_d   = '0;
                end else if (pause) begin
                    cnt_d = cnt_q;
                end else if (cnt_q == CNT_W'(FILL_TICKS - 1)) begin
                    state_d = SETTLE;
                    grant_d = '0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SETTLE: begin
                grant_d = '0;
                if (pause) begin
                    cnt_d = cnt_q;
                end else if (cnt_q == CNT_W'(GAP_TICKS - 1)) begin
                    cnt_d = '0;
                    if (win_vld) begin
                        state_d = GRANT;
                        grant_d = win_oh;
                        gidx_d  = win_idx;
                        rr_d    = win_next;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            cnt_q   <= '0;
            rr_q    <= '0;
            gidx_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
            gidx_q  <= gidx_d;
            busy_q  <= busy_d;
        end
    end

    assign grant      = grant_q;
    assign busy       = busy_q;
    assign fill_cnt   = cnt_q;
    assign valve_open = (state_q == GRANT) & ~pause;

endmodule

// File: doc/water_inlet_arbiter.md
Name: water_inlet_arbiter

Overview:
Shares one mains water inlet valve among NUM_MACHINES washing machine FSMs. Each machine raises a request during its fill phase. The arbiter grants the valve to one machine at a time, round-robin, for at most FILL_TICKS cycles. A SETTLE gap follows each grant so the valve closes before re-arbitration. It sits between the per-machine controllers and the physical valve driver.

Parameters:
NUM_MACHINES, 4, number of requesting machines (2..8)
FILL_TICKS, 10, maximum grant duration in clk cycles (>=1)
GAP_TICKS, 2, valve-closed settle cycles between grants (>=1)
CNT_W, 6, width of fill_cnt; must hold FILL_TICKS-1 and GAP_TICKS-1

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk
req  in  NUM_MACHINES  per-machine water request, level
pause  in  1  global time pause; freezes counters
grant  out  NUM_MACHINES  one-hot (or zero) grant, registered
valve_open  out  1  inlet valve drive
busy  out  1  high whenever state != IDLE, registered
fill_cnt  out  CNT_W  current phase counter value, registered

Behaviour:
- Reset (rst_n low at a clk edge):
  - state=IDLE; grant=0; busy=0; fill_cnt=0; rr_ptr=0 (machine 0 highest priority).
  - Overrides everything, including mid-grant.
- States: IDLE, GRANT, SETTLE.
- Arbitration function:
  - Scan req starting at index rr_ptr, wrapping modulo NUM_MACHINES.
  - First set bit wins.
  - On any new grant to index k, rr_ptr <= (k+1) mod NUM_MACHINES.
- IDLE:
  - If |req, next cycle: state=GRANT, grant=onehot(winner), fill_cnt=0, busy=1. Latency req->grant is 1 cycle.
  - Otherwise remain in IDLE.
- GRANT:
  - If req[granted] is low: next cycle state=SETTLE, grant=0, fill_cnt=0. Early release takes precedence over pause and timeout.
  - Else if pause: hold state, grant and fill_cnt.
  - Else if fill_cnt==FILL_TICKS-1: next cycle SETTLE, grant=0, fill_cnt=0 (timeout).
  - Else fill_cnt+1.
  - Unpaused, a held request sees grant high for exactly FILL_TICKS cycles.
- SETTLE:
  - grant=0.
  - If pause: hold fill_cnt.
  - Else if fill_cnt==GAP_TICKS-1: arbitrate on current req. Winner present -> GRANT with fill_cnt=0; none -> IDLE with busy=0, fill_cnt=0.
  - Else fill_cnt+1.
- valve_open = (state==GRANT) & ~pause. Combinational from registered state; the only non-registered output.
- Request changes from non-granted machines during GRANT/SETTLE have no effect until the next arbitration point.
- A machine still requesting after timeout is re-eligible only at its round-robin turn. With all machines requesting, each is served once per round.
- grant is never more than one-hot. grant!=0 implies state==GRANT.
- Counter never exceeds its phase limit; no wrap-around is possible in valid configurations.

Optional Feature:
WATER_ARB_PRIO_EN:
- Defined:
  - Adds input prio_req [NUM_MACHINES] (e.g. steam-clean or double-wash jobs).
  - At each arbitration point, if |(req & prio_req), the round-robin scan runs over req & prio_req only. Otherwise it runs over req.
  - rr_ptr is shared by both classes.
  - The early-release check still uses req only.
- Undefined: the port is absent and arbitration uses req only.

Test Plan:
1. Single request, idle arbiter (N=4, FILL=10, GAP=2): req=4'b0100 from cycle 0, held.
   -> grant=4'b0100 cycles 1-10; valve_open high 10 cycles; grant=0 cycles 11-12; grant=4'b0100 again from cycle 13.
2. All machines requesting: req=4'b1111 constant.
   -> grant sequence 0001, 0010, 0100, 1000, 0001, each 10 cycles, each followed by a 2-cycle gap; period 48 cycles.
3. Early release: req=4'b0010; drop req[1] on the 4th grant cycle.
   -> grant=0 the next cycle; SETTLE 2 cycles; IDLE with busy=0 afterwards.
4. Pause mid-grant: pause high 5 cycles when fill_cnt=3.
   -> fill_cnt frozen at 3; valve_open low those 5 cycles; grant held; total grant length 15 cycles.
5. Reset mid-operation: rst_n low one edge while grant=4'b1000, then req=4'b1001.
   -> cycle after reset grant=0, busy=0; next grant goes to machine 0 (4'b0001), confirming rr_ptr reset.
6. (WATER_ARB_PRIO_EN) req=4'b1111, prio_req=4'b0100.
   -> first grant 4'b0100, ahead of machine 0; next arbitration grant 4'b0100 again while it requests with priority; with prio_req=0, round-robin resumes at 4'b1000.
